// File: rtl/plab3_mem_wben_serializer.sv
// Splits one masked cache-line write into ascending word-write beats.
// PLAB3_MEM_WBEN_SER_B2B_EN: accept the next line alongside the final beat.
module plab3_mem_wben_serializer #(
    parameter  int p_idx_nbits  = 2,
    localparam int c_nwords     = 1 << p_idx_nbits,
    localparam int c_mask_nbits = 4 * c_nwords,
    localparam int c_line_nbits = 8 * c_mask_nbits
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [c_mask_nbits-1:0] in_wben,
    input  logic [c_line_nbits-1:0] in_data,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [p_idx_nbits-1:0]  out_idx,
    output logic [3:0]              out_byten,
    output logic [31:0]             out_data,
    output logic                    out_last
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state;
    logic [c_mask_nbits-1:0] mask_q;
    logic [c_line_nbits-1:0] data_q;
    logic                    rdy_q;

    logic [p_idx_nbits-1:0]  idx;
    logic [c_mask_nbits-1:0] clr;
    logic [c_mask_nbits-1:0] rest;
    logic                    busy;
    logic                    in_fire;
    logic                    out_fire;

    // Priority pick of the lowest word that still has enabled bytes
    always_comb begin
        idx = '0;
        for (int w = c_nwords - 1; w >= 0; w--) begin
            if (mask_q[4*w +: 4] != 4'h0) idx = p_idx_nbits'(w);
        end
    end

    assign clr  = {{(c_mask_nbits-4){1'b0}}, 4'hF} << {idx, 2'b00};
    assign rest = mask_q & ~clr;
    assign busy = (state == BUSY);

    assign out_val   = busy;
    assign out_idx   = idx;
    assign out_byten = mask_q[{idx, 2'b00} +: 4];
    assign out_data  = data_q[{idx, 5'b00000} +: 32];
    assign out_last  = busy && (rest == '0);

`ifdef PLAB3_MEM_WBEN_SER_B2B_EN
    assign in_rdy = rdy_q | (busy & out_last & out_rdy);
`else
    assign in_rdy = rdy_q;
`endif

    assign in_fire  = in_val & in_rdy;
    assign out_fire = out_val & out_rdy;

    // rdy_q stays low for the first cycle after reset release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mask_q <= '0;
            data_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= (state == IDLE);
            if (out_fire) begin
                mask_q <= rest;
                if (out_last) begin
                    state <= IDLE;
                    rdy_q <= 1'b1;
                end
            end
            if (in_fire) begin
                mask_q <= in_wben;
                data_q <= in_data;
                state  <= (in_wben != '0) ? BUSY : IDLE;
                rdy_q  <= (in_wben == '0);
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        out_val |-> (out_byten != 4'h0));

endmodule
